// File: rtl/ofdm_status.sv
// ofdm_status
// Status and interrupt return path from the OFDM datapath to the processing
// system. Per-block error strobes and frame start/end events become sticky
// write-1-to-clear flags, a wrapping frame counter, a saturating error
// counter, a first-error capture and a maskable level interrupt. All
// outputs are registered and feed the AXI-lite read mux.
//
// Optional feature macro: OFDM_STATUS_TIMEOUT_EN
//   When defined, a frame watchdog flags sticky bit NUM_ERR+2 and forces the
//   frame FSM back to IDLE once a frame has been open for timeout_reg cycles.
//   When undefined, timeout_reg is ignored and that bit always reads 0.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   err_in       single-cycle error strobes {qam, pre, pil, fft, cyc, data}
//   frame_start  pulse on first sample of an OFDM frame
//   frame_end    pulse on last sample of an OFDM frame
//   clr_reg      write-1-to-clear pattern; bit 31 clears counters/capture
//   clr_valid    one-cycle strobe qualifying clr_reg
//   mask_reg     interrupt mask, 1 = masked
//   timeout_reg  frame watchdog limit in cycles (0 = disabled)
//   status_reg0  sticky flags
//   status_reg1  completed-frame count, zero-extended
//   status_reg2  error-event count, zero-extended
//   status_reg3  {first_err_valid[31], first_err_idx[15:8], state[1:0]}
//   irq          level interrupt

module ofdm_status #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_ERR            = 6,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_ERR-1:0]            err_in,
    input  logic                          frame_start,
    input  logic                          frame_end,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] clr_reg,
    input  logic                          clr_valid,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] mask_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] timeout_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0] status_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0] status_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0] status_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0] status_reg3,
    output logic                          irq
);

    localparam int NUM_FLAGS = NUM_ERR + 3;
    localparam int BIT_OVR   = NUM_ERR;
    localparam int BIT_UND   = NUM_ERR + 1;
    localparam int BIT_TMO   = NUM_ERR + 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_FRAME = 2'd1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   overrun;
    logic                   underrun;
    logic                   frame_done;
    logic                   frame_open;
    logic                   timeout_hit;
    logic [NUM_FLAGS-1:0]   sticky;
    logic [NUM_FLAGS-1:0]   flag_set;
    logic [NUM_FLAGS-1:0]   flag_clr;
    logic [CNT_WIDTH-1:0]   frame_cnt;
    logic [CNT_WIDTH-1:0]   err_cnt;
    logic                   first_err_valid;
    logic [7:0]             first_err_idx;
    logic [7:0]             lowest_idx;
    logic                   capture_en;
    logic                   cnt_clr;
    logic                   unused_clr;

    // Only the flag bits and bit 31 of the clear word have a meaning.
    assign unused_clr = ^clr_reg[C_S_AXI_DATA_WIDTH-2:NUM_FLAGS];

`ifdef OFDM_STATUS_TIMEOUT_EN
    logic [C_S_AXI_DATA_WIDTH-1:0] wd_cnt;

    // Watchdog counts cycles spent in the current frame; restarts whenever a
    // frame is (re)opened.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (frame_open) begin
            wd_cnt <= '0;
        end else if (state == IN_FRAME) begin
            wd_cnt <= wd_cnt + C_S_AXI_DATA_WIDTH'(1);
        end
    end

    assign timeout_hit = (state == IN_FRAME) && (timeout_reg != '0) &&
                         (wd_cnt == timeout_reg);
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_reg;
    assign timeout_hit    = 1'b0;
`endif

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state. A watchdog expiry wins over any same-cycle frame event.
    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:     if (frame_start && !frame_end) state_next = IN_FRAME;
                IN_FRAME: if (frame_end && !frame_start) state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // FSM event outputs. Simultaneous start/end closes and reopens a frame
    // when already inside one, or counts a zero-length frame from IDLE.
    always_comb begin
        overrun    = 1'b0;
        underrun   = 1'b0;
        frame_done = 1'b0;
        frame_open = 1'b0;
        if (!timeout_hit) begin
            case (state)
                IDLE: begin
                    if (frame_start && frame_end) frame_done = 1'b1;
                    else if (frame_start)         frame_open = 1'b1;
                    else if (frame_end)           underrun   = 1'b1;
                end
                IN_FRAME: begin
                    if (frame_start && frame_end) begin
                        frame_done = 1'b1;
                        frame_open = 1'b1;
                    end else if (frame_end) begin
                        frame_done = 1'b1;
                    end else if (frame_start) begin
                        overrun = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Set and clear vectors for the sticky flags.
    always_comb begin
        flag_set                = '0;
        flag_set[NUM_ERR-1:0]   = err_in;
        flag_set[BIT_OVR]       = overrun;
        flag_set[BIT_UND]       = underrun;
        flag_set[BIT_TMO]       = timeout_hit;
        flag_clr                = clr_valid ? clr_reg[NUM_FLAGS-1:0] : '0;
    end

    // Index of the lowest flag being set this cycle.
    always_comb begin
        lowest_idx = '0;
        for (int i = NUM_FLAGS - 1; i >= 0; i--) begin
            if (flag_set[i]) lowest_idx = 8'(i);
        end
    end

    assign capture_en = !first_err_valid && (sticky == '0) && (|flag_set);
    assign cnt_clr    = clr_valid && clr_reg[C_S_AXI_DATA_WIDTH-1];

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky & ~flag_clr) | flag_set;
        end
    end

    // Counters and first-error capture; the bulk clear discards any
    // same-cycle increment or capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt       <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (cnt_clr) begin
            frame_cnt       <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else begin
            if (frame_done) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            if ((|err_in) && (err_cnt != '1)) err_cnt <= err_cnt + CNT_WIDTH'(1);
            if (capture_en) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= lowest_idx;
            end
        end
    end

    // irq follows the registered flags, so it lags them by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(status_reg0 & ~mask_reg);
        end
    end

    always_comb begin
        status_reg0                   = '0;
        status_reg0[NUM_FLAGS-1:0]    = sticky;
        status_reg1                   = '0;
        status_reg1[CNT_WIDTH-1:0]    = frame_cnt;
        status_reg2                   = '0;
        status_reg2[CNT_WIDTH-1:0]    = err_cnt;
        status_reg3                   = '0;
        status_reg3[C_S_AXI_DATA_WIDTH-1] = first_err_valid;
        status_reg3[15:8]             = first_err_idx;
        status_reg3[1:0]              = state;
    end

endmodule

// File: tb/tb_ofdm_status.sv
// tb_ofdm_status
// Directed bench for ofdm_status, built with a 4-bit counter width so that
// error saturation and frame-count wrap are reached quickly. Build with
// +define+OFDM_STATUS_TIMEOUT_EN to exercise the frame watchdog.

module tb_ofdm_status;

    localparam int W  = 32;
    localparam int NE = 6;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NE-1:0] err_in;
    logic          frame_start;
    logic          frame_end;
    logic [W-1:0]  clr_reg;
    logic          clr_valid;
    logic [W-1:0]  mask_reg;
    logic [W-1:0]  timeout_reg;
    logic [W-1:0]  status_reg0;
    logic [W-1:0]  status_reg1;
    logic [W-1:0]  status_reg2;
    logic [W-1:0]  status_reg3;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    ofdm_status #(
        .C_S_AXI_DATA_WIDTH(W),
        .NUM_ERR(NE),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .err_in(err_in),
        .frame_start(frame_start),
        .frame_end(frame_end),
        .clr_reg(clr_reg),
        .clr_valid(clr_valid),
        .mask_reg(mask_reg),
        .timeout_reg(timeout_reg),
        .status_reg0(status_reg0),
        .status_reg1(status_reg1),
        .status_reg2(status_reg2),
        .status_reg3(status_reg3),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        err_in      = '0;
        clr_reg     = '1;
        clr_valid   = 1'b1;
        tick();
        clr_valid   = 1'b0;
        clr_reg     = '0;
        tick();
    endtask

    task automatic test_reset;
        rst_n       = 1'b1;
        err_in      = '0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        clr_reg     = '0;
        clr_valid   = 1'b0;
        mask_reg    = '0;
        timeout_reg = '0;
        #3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (status_reg0 !== 32'h0) begin failures++; $display("[TB] FAIL reset_reg0 got=%h exp=%h", status_reg0, 32'h0); end
        checks++; if (status_reg1 !== 32'h0) begin failures++; $display("[TB] FAIL reset_reg1 got=%h exp=%h", status_reg1, 32'h0); end
        checks++; if (status_reg2 !== 32'h0) begin failures++; $display("[TB] FAIL reset_reg2 got=%h exp=%h", status_reg2, 32'h0); end
        checks++; if (status_reg3 !== 32'h0) begin failures++; $display("[TB] FAIL reset_reg3 got=%h exp=%h", status_reg3, 32'h0); end
        checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_first_error;
        err_in = 6'b000100;
        tick();
        err_in = 6'b000001;
        checks++; if (status_reg0 !== 32'h4) begin failures++; $display("[TB] FAIL first_reg0 got=%h exp=%h", status_reg0, 32'h4); end
        checks++; if (status_reg2 !== 32'h1) begin failures++; $display("[TB] FAIL first_cnt got=%h exp=%h", status_reg2, 32'h1); end
        checks++; if (status_reg3 !== 32'h8000_0200) begin failures++; $display("[TB] FAIL first_capture got=%h exp=%h", status_reg3, 32'h8000_0200); end
        checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL first_irq_lag got=%b exp=0", irq); end
        tick();
        err_in = '0;
        checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL first_irq got=%b exp=1", irq); end
        checks++; if (status_reg0 !== 32'h5) begin failures++; $display("[TB] FAIL second_reg0 got=%h exp=%h", status_reg0, 32'h5); end
        checks++; if (status_reg2 !== 32'h2) begin failures++; $display("[TB] FAIL second_cnt got=%h exp=%h", status_reg2, 32'h2); end
        checks++; if (status_reg3 !== 32'h8000_0200) begin failures++; $display("[TB] FAIL capture_frozen got=%h exp=%h", status_reg3, 32'h8000_0200); end
    endtask

    task automatic test_frames;
        clear_all();
        for (int k = 0; k < 3; k++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            if (k == 0) begin
                checks++; if (status_reg3 !== 32'h1) begin failures++; $display("[TB] FAIL in_frame_state got=%h exp=%h", status_reg3, 32'h1); end
            end
            repeat (9) tick();
            frame_end = 1'b1;
            tick();
            frame_end = 1'b0;
        end
        checks++; if (status_reg1 !== 32'd3) begin failures++; $display("[TB] FAIL three_frames got=%h exp=%h", status_reg1, 32'd3); end
        checks++; if (status_reg3[1:0] !== 2'd0) begin failures++; $display("[TB] FAIL idle_after got=%h exp=0", status_reg3[1:0]); end
        checks++; if (status_reg0 !== 32'h0) begin failures++; $display("[TB] FAIL clean_frames got=%h exp=%h", status_reg0, 32'h0); end
        // Overrun: two starts without an end.
        frame_start = 1'b1;
        tick();
        tick();
        frame_start = 1'b0;
        checks++; if (status_reg0 !== 32'h40) begin failures++; $display("[TB] FAIL overrun got=%h exp=%h", status_reg0, 32'h40); end
        checks++; if (status_reg3 !== 32'h8000_0601) begin failures++; $display("[TB] FAIL overrun_capture got=%h exp=%h", status_reg3, 32'h8000_0601); end
        checks++; if (status_reg2 !== 32'h0) begin failures++; $display("[TB] FAIL overrun_errcnt got=%h exp=%h", status_reg2, 32'h0); end
        frame_end = 1'b1;
        tick();
        checks++; if (status_reg1 !== 32'd4) begin failures++; $display("[TB] FAIL close_after_overrun got=%h exp=%h", status_reg1, 32'd4); end
        // Underrun: end while idle.
        tick();
        frame_end = 1'b0;
        checks++; if (status_reg0 !== 32'hC0) begin failures++; $display("[TB] FAIL underrun got=%h exp=%h", status_reg0, 32'hC0); end
        checks++; if (status_reg1 !== 32'd4) begin failures++; $display("[TB] FAIL underrun_nocount got=%h exp=%h", status_reg1, 32'd4); end
        // Simultaneous start/end from IDLE.
        frame_start = 1'b1;
        frame_end   = 1'b1;
        tick();
        checks++; if (status_reg1 !== 32'd5) begin failures++; $display("[TB] FAIL both_idle_count got=%h exp=%h", status_reg1, 32'd5); end
        checks++; if (status_reg3[1:0] !== 2'd0) begin failures++; $display("[TB] FAIL both_idle_state got=%h exp=0", status_reg3[1:0]); end
        // Simultaneous start/end inside a frame.
        frame_end = 1'b0;
        tick();
        frame_end = 1'b1;
        tick();
        checks++; if (status_reg1 !== 32'd6) begin failures++; $display("[TB] FAIL both_inframe_count got=%h exp=%h", status_reg1, 32'd6); end
        checks++; if (status_reg3[1:0] !== 2'd1) begin failures++; $display("[TB] FAIL both_inframe_state got=%h exp=1", status_reg3[1:0]); end
        frame_start = 1'b0;
        tick();
        frame_end = 1'b0;
        checks++; if (status_reg1 !== 32'd7) begin failures++; $display("[TB] FAIL reopened_close got=%h exp=%h", status_reg1, 32'd7); end
        // Frame counter wrap: 7 + 9 = 16 -> 0, then 1.
        frame_start = 1'b1;
        frame_end   = 1'b1;
        repeat (9) tick();
        checks++; if (status_reg1 !== 32'd0) begin failures++; $display("[TB] FAIL frame_wrap got=%h exp=%h", status_reg1, 32'd0); end
        tick();
        frame_start = 1'b0;
        frame_end   = 1'b0;
        checks++; if (status_reg1 !== 32'd1) begin failures++; $display("[TB] FAIL frame_after_wrap got=%h exp=%h", status_reg1, 32'd1); end
    endtask

    task automatic test_set_wins;
        clear_all();
        err_in = 6'b000001;
        tick();
        clr_reg   = 32'h1;
        clr_valid = 1'b1;
        tick();
        err_in = '0;
        checks++; if (status_reg0 !== 32'h1) begin failures++; $display("[TB] FAIL set_wins got=%h exp=%h", status_reg0, 32'h1); end
        tick();
        clr_valid = 1'b0;
        clr_reg   = '0;
        checks++; if (status_reg0 !== 32'h0) begin failures++; $display("[TB] FAIL w1c got=%h exp=%h", status_reg0, 32'h0); end
        checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_hold got=%b exp=1", irq); end
        checks++; if (status_reg2 !== 32'd2) begin failures++; $display("[TB] FAIL held_err_cnt got=%h exp=%h", status_reg2, 32'd2); end
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL irq_fall got=%b exp=0", irq); end
    endtask

    task automatic test_mask;
        clear_all();
        mask_reg = 32'h3F;
        err_in   = 6'h3F;
        tick();
        err_in = '0;
        checks++; if (status_reg0 !== 32'h3F) begin failures++; $display("[TB] FAIL all_flags got=%h exp=%h", status_reg0, 32'h3F); end
        checks++; if (status_reg3 !== 32'h8000_0000) begin failures++; $display("[TB] FAIL lowest_idx got=%h exp=%h", status_reg3, 32'h8000_0000); end
        tick();
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL masked_irq got=%b exp=0", irq); end
        mask_reg = 32'h0;
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL unmasked_irq got=%b exp=1", irq); end
        mask_reg = 32'h3E;
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL partial_mask_irq got=%b exp=1", irq); end
        mask_reg = 32'hFFFF_FFFF;
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL remask_irq got=%b exp=0", irq); end
        mask_reg = 32'h0;
    endtask

    task automatic test_saturation;
        clear_all();
        for (int i = 0; i < 20; i++) begin
            err_in = 6'(1 << (i % 6));
            tick();
            if (i == 13) begin
                checks++; if (status_reg2 !== 32'd14) begin failures++; $display("[TB] FAIL below_sat got=%h exp=%h", status_reg2, 32'd14); end
            end
        end
        err_in = '0;
        checks++; if (status_reg2 !== 32'd15) begin failures++; $display("[TB] FAIL saturated got=%h exp=%h", status_reg2, 32'd15); end
        // Bulk clear with a same-cycle error: increment is dropped.
        clr_reg   = 32'h8000_0000;
        clr_valid = 1'b1;
        err_in    = 6'b000001;
        tick();
        clr_valid = 1'b0;
        clr_reg   = '0;
        err_in    = '0;
        checks++; if (status_reg2 !== 32'h0) begin failures++; $display("[TB] FAIL cnt_clear got=%h exp=%h", status_reg2, 32'h0); end
        checks++; if (status_reg3[31] !== 1'b0) begin failures++; $display("[TB] FAIL capture_clear got=%b exp=0", status_reg3[31]); end
        checks++; if (status_reg0 !== 32'h3F) begin failures++; $display("[TB] FAIL flags_kept got=%h exp=%h", status_reg0, 32'h3F); end
    endtask

    task automatic test_timeout;
        clear_all();
        timeout_reg = 32'd50;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (45) tick();
        checks++; if (status_reg0[8] !== 1'b0) begin failures++; $display("[TB] FAIL early_timeout got=%b exp=0", status_reg0[8]); end
        checks++; if (status_reg3[1:0] !== 2'd1) begin failures++; $display("[TB] FAIL still_in_frame got=%h exp=1", status_reg3[1:0]); end
        repeat (15) tick();
`ifdef OFDM_STATUS_TIMEOUT_EN
        checks++; if (status_reg0[8] !== 1'b1) begin failures++; $display("[TB] FAIL timeout_flag got=%b exp=1", status_reg0[8]); end
        checks++; if (status_reg3[1:0] !== 2'd0) begin failures++; $display("[TB] FAIL timeout_idle got=%h exp=0", status_reg3[1:0]); end
        checks++; if (status_reg1 !== 32'd0) begin failures++; $display("[TB] FAIL timeout_nocount got=%h exp=%h", status_reg1, 32'd0); end
`else
        checks++; if (status_reg0[8] !== 1'b0) begin failures++; $display("[TB] FAIL no_watchdog got=%b exp=0", status_reg0[8]); end
        checks++; if (status_reg3[1:0] !== 2'd1) begin failures++; $display("[TB] FAIL no_watchdog_state got=%h exp=1", status_reg3[1:0]); end
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        checks++; if (status_reg1 !== 32'd1) begin failures++; $display("[TB] FAIL long_frame_count got=%h exp=%h", status_reg1, 32'd1); end
`endif
        timeout_reg = '0;
    endtask

    task automatic test_async_reset;
        err_in = 6'b000010;
        tick();
        err_in = '0;
        rst_n  = 1'b0;
        #2;
        checks++; if (status_reg0 !== 32'h0) begin failures++; $display("[TB] FAIL async_reg0 got=%h exp=%h", status_reg0, 32'h0); end
        checks++; if (status_reg2 !== 32'h0) begin failures++; $display("[TB] FAIL async_reg2 got=%h exp=%h", status_reg2, 32'h0); end
        checks++; if (status_reg3 !== 32'h0) begin failures++; $display("[TB] FAIL async_reg3 got=%h exp=%h", status_reg3, 32'h0); end
        #10;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_error();
        test_frames();
        test_set_wins();
        test_mask();
        test_saturation();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
